// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback requesters.
// Build option: define REGWR_FIXED_PRIO_EN for fixed priority (lowest valid index wins, ptr held at 0).
module regfile_write_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SEL_W-1:0]    req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wr_en,
  output logic [SEL_W-1:0]         wr_sel,
  output logic [DATA_W-1:0]        wr_data,
  output logic [2:0]               wr_src
);

  logic [2:0]        ptr;
  logic              grant_any;
  logic [2:0]        gidx;
  logic [NREQ-1:0]   grant;
  logic [SEL_W-1:0]  gaddr;
  logic [DATA_W-1:0] gdata;

  // Two passes replace a rotated scan: first indices at or above ptr, then the wrap-around.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    gidx      = '0;
    gaddr     = '0;
    gdata     = '0;
    if (reset_n && !stall) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (3'(i) >= ptr)) begin
          grant_any = 1'b1;
          gidx      = 3'(i);
          grant[i]  = 1'b1;
          gaddr     = req_addr[i*SEL_W +: SEL_W];
          gdata     = req_data[i*DATA_W +: DATA_W];
        end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i]) begin
          grant_any = 1'b1;
          gidx      = 3'(i);
          grant[i]  = 1'b1;
          gaddr     = req_addr[i*SEL_W +: SEL_W];
          gdata     = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign req_ready = grant;

`ifdef REGWR_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [2:0] ptr_next;

  always_comb begin
    ptr_next = ptr;
    if (grant_any) begin
      if (32'(gidx) == NREQ - 1)
        ptr_next = '0;
      else
        ptr_next = gidx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= '0;
    else
      ptr <= ptr_next;
  end
`endif

  // Select, enable and data leave from one register stage so the decoder sees them change together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
      wr_src  <= '0;
    end else begin
      wr_en <= grant_any;
      if (grant_any) begin
        wr_sel  <= gaddr;
        wr_data <= gdata;
        wr_src  <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven bench for regfile_write_arbiter with a scoreboard queue of expected writes.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SEL_W  = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   stall;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*SEL_W-1:0]  req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_en;
  logic [SEL_W-1:0]       wr_sel;
  logic [DATA_W-1:0]      wr_data;
  logic [2:0]             wr_src;

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_src(wr_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   valid;
    logic         stall;
    logic [3:0]   exp_ready;
    logic [11:0]  addr;
    logic [255:0] data;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [63:0] data;
    logic [2:0]  src;
  } wr_t;

  localparam logic [11:0]  CONT_A = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [255:0] CONT_D = {64'h13, 64'h12, 64'h11, 64'h10};
  localparam logic [11:0]  SNGL_A = {3'd3, 3'd5, 3'd1, 3'd0};
  localparam logic [255:0] SNGL_D = {64'h13, 64'hDEAD, 64'h11, 64'h10};
  localparam logic [11:0]  COLL_A = {3'd3, 3'd2, 3'd7, 3'd7};
  localparam logic [255:0] COLL_D = {64'h13, 64'h12, 64'hBBBB, 64'hAAAA};

  wr_t         exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [2:0]  last_sel;
  logic [2:0]  last_src;
  logic [63:0] last_data;
  vec_t        tbl[18];

  function automatic vec_t mk(input logic [3:0] valid, input logic stl, input logic [3:0] er,
                              input logic [11:0] a, input logic [255:0] d);
    vec_t v;
    v.valid = valid; v.stall = stl; v.exp_ready = er; v.addr = a; v.data = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic check_out(input string tag);
    wr_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, " wr_en"},   64'(wr_en),  64'd1);
      chk({tag, " wr_sel"},  64'(wr_sel), 64'(e.sel));
      chk({tag, " wr_data"}, wr_data,     e.data);
      chk({tag, " wr_src"},  64'(wr_src), 64'(e.src));
      last_sel = e.sel; last_data = e.data; last_src = e.src;
    end else begin
      chk({tag, " wr_en idle"},   64'(wr_en),  64'd0);
      chk({tag, " wr_sel hold"},  64'(wr_sel), 64'(last_sel));
      chk({tag, " wr_data hold"}, wr_data,     last_data);
      chk({tag, " wr_src hold"},  64'(wr_src), 64'(last_src));
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic run_vec(input vec_t v, input string tag);
    wr_t e;
    req_valid = v.valid; stall = v.stall; req_addr = v.addr; req_data = v.data;
    #2;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(v.exp_ready));
    for (int i = 0; i < 4; i++) begin
      if (v.exp_ready[i]) begin
        e.sel = v.addr[i*3 +: 3]; e.data = v.data[i*64 +: 64]; e.src = 3'(i);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_out(tag);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; req_valid = '1; req_addr = CONT_A; req_data = CONT_D;
    last_sel = '0; last_data = '0; last_src = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset wr_en",     64'(wr_en),     64'd0);
    chk("reset wr_sel",    64'(wr_sel),    64'd0);
    chk("reset wr_data",   wr_data,        64'd0);
    chk("reset wr_src",    64'(wr_src),    64'd0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef REGWR_FIXED_PRIO_EN
    for (int r = 0; r < 6; r++)
      run_vec(mk(4'b1001, 1'b0, 4'b0001, CONT_A, CONT_D), $sformatf("fixed%0d", r));
    run_vec(mk(4'b0000, 1'b0, 4'b0000, CONT_A, CONT_D), "fixed_idle");
`else
    tbl[0]  = mk(4'b1111, 1'b0, 4'b0001, CONT_A, CONT_D);
    tbl[1]  = mk(4'b1110, 1'b0, 4'b0010, CONT_A, CONT_D);
    tbl[2]  = mk(4'b1100, 1'b0, 4'b0100, CONT_A, CONT_D);
    tbl[3]  = mk(4'b1000, 1'b0, 4'b1000, CONT_A, CONT_D);
    tbl[4]  = mk(4'b0000, 1'b0, 4'b0000, CONT_A, CONT_D);
    tbl[5]  = mk(4'b0100, 1'b0, 4'b0100, SNGL_A, SNGL_D);
    tbl[6]  = mk(4'b0000, 1'b0, 4'b0000, SNGL_A, SNGL_D);
    tbl[7]  = mk(4'b1001, 1'b0, 4'b1000, SNGL_A, SNGL_D);
    tbl[8]  = mk(4'b0001, 1'b0, 4'b0001, SNGL_A, SNGL_D);
    tbl[9]  = mk(4'b1000, 1'b0, 4'b1000, COLL_A, COLL_D);
    tbl[10] = mk(4'b0011, 1'b0, 4'b0001, COLL_A, COLL_D);
    tbl[11] = mk(4'b0010, 1'b0, 4'b0010, COLL_A, COLL_D);
    tbl[12] = mk(4'b1111, 1'b0, 4'b0100, CONT_A, CONT_D);
    tbl[13] = mk(4'b1111, 1'b1, 4'b0000, CONT_A, CONT_D);
    tbl[14] = mk(4'b1111, 1'b1, 4'b0000, CONT_A, CONT_D);
    tbl[15] = mk(4'b1111, 1'b1, 4'b0000, CONT_A, CONT_D);
    tbl[16] = mk(4'b1111, 1'b0, 4'b1000, CONT_A, CONT_D);
    tbl[17] = mk(4'b1111, 1'b0, 4'b0001, CONT_A, CONT_D);
    for (int r = 0; r < 18; r++)
      run_vec(tbl[r], $sformatf("row%0d", r));

    begin : mid_reset
      wr_t e;
      req_valid = 4'b1111; stall = 1'b0; req_addr = CONT_A; req_data = CONT_D;
      #2;
      chk("burst req_ready", 64'(req_ready), 64'b0010);
      e.sel = 3'd1; e.data = 64'h11; e.src = 3'd1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out("burst");
      #1 reset_n = 1'b0;
      #1;
      chk("midreset wr_en",     64'(wr_en),     64'd0);
      chk("midreset wr_sel",    64'(wr_sel),    64'd0);
      chk("midreset wr_data",   wr_data,        64'd0);
      chk("midreset wr_src",    64'(wr_src),    64'd0);
      chk("midreset req_ready", 64'(req_ready), 64'd0);
      exp_q.delete();
      last_sel = '0; last_data = '0; last_src = '0;
      #1 reset_n = 1'b1;
      @(negedge clk);
    end
    run_vec(mk(4'b1111, 1'b0, 4'b0001, CONT_A, CONT_D), "post_reset");
    run_vec(mk(4'b0000, 1'b0, 4'b0000, CONT_A, CONT_D), "post_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between up to NREQ writeback requesters (ALU, load, branch-link, ...). Each cycle it grants at most one request, round-robin, and drives the 3-bit write select, write enable and write data into the register file. The 3-to-8 write decoder then sees select and enable change together from one register stage, never from raw requester signals.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DATA_W, 64: register data width.
- SEL_W, 3: register select width (fixed 3 for the 8-entry file).
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold; no grants while high.
- req_valid  in  NREQ  request i pending.
- req_addr  in  NREQ*SEL_W  destination of requester i (slice i).
- req_data  in  NREQ*DATA_W  write data of requester i (slice i).
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready.
- wr_en  out  1  decoder enable / register-file write strobe.
- wr_sel  out  SEL_W  decoder select.
- wr_data  out  DATA_W  data to register file.
- wr_src  out  3  index of requester that produced current write.

## Operation
- Requester contract: once req_valid[i] rises it holds valid, addr and data stable until req_ready[i]; no retraction.
- Arbiter (combinational): if stall=0, scan i = ptr, ptr+1, ... mod NREQ; first valid index g gets req_ready[g]=1; all other ready bits 0. If stall=1 or no valid, req_ready = 0.
- Pointer register ptr (3 bits): on grant g, ptr <= (g+1) mod NREQ; no grant -> unchanged.
- Output stage (registered): on grant, wr_en<=1, wr_sel<=req_addr[g], wr_data<=req_data[g], wr_src<=g. No grant -> wr_en<=0; wr_sel, wr_data, wr_src hold.
- Two requesters with the same address in one cycle: both are written, in grant order, in consecutive cycles. The later grant wins in the register file. No merging.
- Starvation bound: a continuously valid requester is granted within NREQ cycles of stall=0 cycles.
- Reset (asynchronous, any time, including mid-burst): ptr=0, wr_en=0, wr_sel=0, wr_data=0, wr_src=0. req_ready is 0 while reset_n=0. An in-flight registered write is dropped. Pending requests are re-arbitrated after release.

## Timing
- Grant in cycle N (req_ready high, combinational from req_valid/ptr/stall); write visible at outputs cycle N+1. Latency 1.
- Throughput: one write per cycle, sustained.
- wr_en is a single-cycle pulse per grant. Back-to-back grants keep wr_en high across cycles.
- stall rising in cycle N: no grant in N; wr_en=0 from N+1. The write granted in N-1 still issues in N.
- First edge after reset_n deassertion may grant. Outputs stay at reset values until then.

## Configuration
- REGWR_FIXED_PRIO_EN defined: ptr is ignored and held at 0. The lowest valid index always wins, and starvation is permitted.
- Not defined: round-robin as above.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: hold reset_n=0 with all req_valid=1. Required: req_ready=0, wr_en=0, wr_sel=0, wr_data=0. Release reset: the next edge grants requester 0.
- Single requester: req 2 valid, addr=5, data=0xDEAD. Required: req_ready=4'b0100 in cycle N; in cycle N+1, wr_en=1, wr_sel=5, wr_data=0xDEAD, wr_src=2; ptr becomes 3.
- Contention: all four valid from reset, each requester i with addr=i and data=i+0x10, each dropping valid after its grant. Required grants in order 0,1,2,3; wr_en high for 4 consecutive cycles with wr_sel sequence 0,1,2,3.
- Same-address collision: req 0 and req 1 both valid, addr=7, data A and B. Required: two writes, A then B; wr_sel=7 both cycles.
- Stall and reset mid-burst: with all requests valid, raise stall for 3 cycles. Required: req_ready=0 and wr_en=0 from the next cycle; arbitration resumes at the saved ptr after the stall. Then pulse reset_n low between edges. Required: wr_en=0 immediately and ptr=0.
- REGWR_FIXED_PRIO_EN build: req 0 and req 3 held valid. Required: req 0 is granted every cycle and req 3 is never granted.
